// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - oversampling UART receiver with parity, stop-bit and overrun reporting
// Holds one received word behind a valid/ready handshake; later frames are dropped while it waits.
module uart_rx_param #(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1,
    parameter int OVERSAMPLE  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 tick_i,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 parity_err_o,
    output logic                 frame_err_o,
    output logic                 overrun_o,
    input  logic                 clr_i,
    output logic                 busy_o
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] HALF_M1   = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_M1   = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
    localparam logic          ODD       = (PARITY_MODE == 2);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                 state_q, state_d;
    logic [1:0]             sync_q;
    logic                   rx_s;
    logic                   rx_prev_q;
    logic [CW-1:0]          cnt_q;
    logic [BW-1:0]          bit_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   pe_acc_q;
    logic                   fe_acc_q;
    logic                   at_sample;
    logic                   frame_done;
    logic                   par_err_calc;
    logic                   fe_final;

    assign rx_s         = sync_q[1];
    assign busy_o       = (state_q != IDLE);
    assign par_err_calc = (^shift_q) ^ rx_s ^ ODD;
    assign fe_final     = fe_acc_q | ~rx_s;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx_i};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        at_sample  = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            IDLE: begin
                // rx_prev_q only advances on ticks, so a held-low line never looks like a new edge
                if (tick_i && rx_prev_q && !rx_s) begin
                    state_d = START;
                end
            end
            START: begin
                if (tick_i && cnt_q == HALF_M1) begin
                    at_sample = 1'b1;
                    state_d   = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick_i && cnt_q == FULL_M1) begin
                    at_sample = 1'b1;
                    if (bit_q == LAST_DATA) begin
                        state_d = (PARITY_MODE != 0) ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (tick_i && cnt_q == FULL_M1) begin
                    at_sample = 1'b1;
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (tick_i && cnt_q == FULL_M1) begin
                    at_sample = 1'b1;
                    if (bit_q == LAST_STOP) begin
                        state_d    = IDLE;
                        frame_done = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_prev_q <= 1'b1;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '1;
            pe_acc_q  <= 1'b0;
            fe_acc_q  <= 1'b0;
        end else if (tick_i) begin
            rx_prev_q <= rx_s;
            if (state_q == IDLE) begin
                cnt_q    <= '0;
                bit_q    <= '0;
                pe_acc_q <= 1'b0;
                fe_acc_q <= 1'b0;
            end else if (at_sample) begin
                cnt_q <= '0;
                case (state_q)
                    DATA: begin
                        shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
                        bit_q   <= (bit_q == LAST_DATA) ? '0 : bit_q + BW'(1);
                    end
                    PARITY:  pe_acc_q <= par_err_calc;
                    STOP: begin
                        fe_acc_q <= fe_final;
                        bit_q    <= bit_q + BW'(1);
                    end
                    default: bit_q <= '0;
                endcase
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_o       <= '0;
            valid_o      <= 1'b0;
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
            overrun_o    <= 1'b0;
        end else begin
            if (frame_done && (!valid_o || ready_i)) begin
                data_o       <= shift_q;
                parity_err_o <= pe_acc_q;
                frame_err_o  <= fe_final;
                valid_o      <= 1'b1;
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
            // A drop in the same cycle as clr_i must still be reported
            if (frame_done && valid_o && !ready_i) begin
                overrun_o <= 1'b1;
            end else if (clr_i) begin
                overrun_o <= 1'b0;
            end
        end
    end

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL provide parameter DATA_BITS, default 8, number of data bits per frame; legal range 5..9.
REQ-002 SHALL provide parameter PARITY_MODE, default 0, parity mode: 0 = none, 1 = even, 2 = odd.
REQ-003 SHALL provide parameter STOP_BITS, default 1, number of stop bits; legal values 1 or 2.
REQ-004 SHALL provide parameter OVERSAMPLE, default 16, number of tick_i pulses per bit; even, minimum 8.
REQ-005 SHALL have port clk_i, input, 1, system clock.
REQ-006 SHALL have port rst_i, input, 1, reset; asynchronous, active-high.
REQ-007 SHALL have port tick_i, input, 1, single-cycle oversample enable at OVERSAMPLE x baud rate.
REQ-008 SHALL have port rx_i, input, 1, serial line; asynchronous; idle high.
REQ-009 SHALL have port data_o, output, DATA_BITS, received word, LSB = first bit received.
REQ-010 SHALL have port valid_o, output, 1, data_o and the per-frame flags are valid.
REQ-011 SHALL have port ready_i, input, 1, consumer accepts the word.
REQ-012 SHALL have port parity_err_o, output, 1, parity mismatch for the held word.
REQ-013 SHALL have port frame_err_o, output, 1, a stop bit was sampled low for the held word.
REQ-014 SHALL have port overrun_o, output, 1, sticky: a frame was dropped.
REQ-015 SHALL have port clr_i, input, 1, single-cycle pulse that clears overrun_o.
REQ-016 SHALL have port busy_o, output, 1, high whenever the state machine is not IDLE.

Function
REQ-017 SHALL synchronise rx_i through a 2-flop synchroniser; all sampling uses the synchronised value.
REQ-018 SHALL implement the states IDLE, START, DATA, PARITY, STOP.
- All state transitions and samples happen only in cycles where tick_i = 1.
REQ-019 In IDLE, on a high-to-low transition of the synchronised line, the machine SHALL clear the oversample counter and enter START.
REQ-020 In START, after OVERSAMPLE/2 ticks the machine SHALL sample the line.
- Low: reset the counter and enter DATA.
- High: treat as a false start and return to IDLE with no output.
REQ-021 In DATA, the machine SHALL sample each bit after OVERSAMPLE ticks and shift the bits in LSB first.
- After DATA_BITS samples: enter PARITY if PARITY_MODE != 0, otherwise enter STOP.
REQ-022 In PARITY, the machine SHALL sample one bit and compute parity_err.
- Even mode: error = XOR of the data bits and the parity bit.
- Odd mode: error = the inverse of that XOR.
REQ-023 In STOP, the machine SHALL sample STOP_BITS bits; any low sample sets frame_err.
- After the last stop sample, the frame completes and the machine returns to IDLE.
- A new falling edge is needed to restart, so a held-low line (break) does not retrigger.
REQ-024 On frame completion with valid_o = 0, the block SHALL, in the next clk_i cycle:
- load data_o, parity_err_o and frame_err_o;
- assert valid_o.
REQ-025 valid_o SHALL stay high, and data_o and the flags SHALL stay stable, until a cycle with valid_o = 1 and ready_i = 1; valid_o deasserts on the following edge.
REQ-026 If a frame completes in the same cycle that valid_o and ready_i are both high, the new word SHALL be loaded and valid_o SHALL remain high, with no overrun.
REQ-027 If a frame completes while valid_o = 1 and ready_i = 0, the new frame SHALL be discarded and overrun_o SHALL be set.
REQ-028 clr_i SHALL clear overrun_o; if clr_i coincides with a new overrun event, the set wins.
REQ-029 parity_err_o SHALL be 0 for every word when PARITY_MODE = 0.

Reset
REQ-030 While rst_i is high, the block SHALL drive the following values:
- state = IDLE;
- counters = 0;
- shift register = all 1s;
- synchroniser flops = 1;
- data_o = 0, valid_o = 0, parity_err_o = 0, frame_err_o = 0, overrun_o = 0, busy_o = 0.
REQ-031 Reset asserted mid-frame SHALL abandon the frame.
- After release, no word is emitted until a complete new frame is received.

Verification
REQ-032 8N1, OVERSAMPLE=16, send 0x55 with ready_i=1 -> one valid_o pulse, data_o=0x55, both error flags 0.
REQ-033 8E1, send 0xA3 with parity bit 1 (wrong, expected 0) -> data_o=0xA3, parity_err_o=1, frame_err_o=0.
REQ-034 rx_i low glitch of 4 ticks then high -> busy_o returns to 0, valid_o never asserts.
REQ-035 ready_i=0, send 0x12 then 0x34 -> data_o holds 0x12, overrun_o=1; clr_i pulse -> overrun_o=0.
REQ-036 8N2, second stop bit driven low, send 0xF0 -> data_o=0xF0, frame_err_o=1; line held low afterwards -> no further valid_o.
REQ-037 rst_i pulsed during data bit 4 of 0x3C, then 0x81 sent -> only one word delivered, data_o=0x81.
